// File: rtl/common_types_pkg.sv
// Shared types, access-size codes and lane helpers for the load/store unit.
// The misalignment check is only consumed when LSU_MISALIGN_TRAP_EN is defined.
package common_types_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } lsu_state_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Size code 3 falls into the default arm everywhere, so it behaves as a word.
    function automatic logic [3:0] lsuStrobe(input logic [1:0] size, input logic [1:0] addr);
        case (size)
            SIZE_BYTE: return 4'b0001 << addr;
            SIZE_HALF: return 4'b0011 << {addr[1], 1'b0};
            default:   return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] lsuWdata(input logic [1:0] size, input logic [31:0] data);
        case (size)
            SIZE_BYTE: return {4{data[7:0]}};
            SIZE_HALF: return {2{data[15:0]}};
            default:   return data;
        endcase
    endfunction

    function automatic logic lsuMisaligned(input logic [1:0] size, input logic [1:0] addr);
        case (size)
            SIZE_BYTE: return 1'b0;
            SIZE_HALF: return addr[0];
            default:   return |addr;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load lane selection and sign/zero extension of the bus read word.
module lsu_load_align
    import common_types_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr,
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    output logic [31:0] o_word
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rdata[{i_addr, 3'b000} +: 8];
    assign w_half = i_rdata[{i_addr[1], 4'b0000} +: 16];

    always_comb begin
        o_word = i_rdata;
        case (i_size)
            SIZE_BYTE: o_word = {{24{i_signed & w_byte[7]}}, w_byte};
            SIZE_HALF: o_word = {{16{i_signed & w_half[15]}}, w_half};
            default:   o_word = i_rdata;
        endcase
    end

endmodule

// File: rtl/lsu_controller.sv
// Memory-stage load/store controller: one outstanding bus access, stall and completion signalling.
// Optional misaligned-access trap with misalign output is enabled by defining LSU_MISALIGN_TRAP_EN.
module lsu_controller
    import common_types_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] dload,
    output logic        mem_ren,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_strb,
`ifdef LSU_MISALIGN_TRAP_EN
    output logic        misalign,
`endif
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    lsu_state_t  r_state;
    lsu_state_t  w_nextState;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [1:0]  r_size;
    logic        r_signed;
    logic        r_isWrite;
    logic        r_flushed;
    logic [31:0] r_dload;
    logic [31:0] w_loadWord;
    logic        w_start;
    logic        w_squash;
    logic        w_misStart;

    assign w_start  = (req_read | req_write) & ~flush;
    // A flush seen at any point during ACCESS squashes the result once the bus completes.
    assign w_squash = r_flushed | flush;

`ifdef LSU_MISALIGN_TRAP_EN
    logic r_misalign;

    assign w_misStart = lsuMisaligned(req_size, req_addr[1:0]);
    assign misalign   = r_misalign;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_misalign <= 1'b0;
        end else if (r_state == IDLE && w_start) begin
            r_misalign <= w_misStart;
        end else if (r_state == DONE) begin
            r_misalign <= 1'b0;
        end
    end
`else
    assign w_misStart = 1'b0;
`endif

    lsu_load_align u_align (
        .i_rdata  (mem_rdata),
        .i_addr   (r_addr[1:0]),
        .i_size   (r_size),
        .i_signed (r_signed),
        .o_word   (w_loadWord)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_start) w_nextState = w_misStart ? DONE : ACCESS;
            ACCESS:  if (mem_ready) w_nextState = w_squash ? IDLE : DONE;
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        done      = (r_state == DONE);
        mem_ren   = 1'b0;
        mem_wen   = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        mem_strb  = 4'h0;
        if (r_state == ACCESS) begin
            mem_ren  = ~r_isWrite;
            mem_wen  = r_isWrite;
            mem_addr = {r_addr[31:2], 2'b00};
            if (r_isWrite) begin
                mem_wdata = lsuWdata(r_size, r_wdata);
                mem_strb  = lsuStrobe(r_size, r_addr[1:0]);
            end
        end
    end

    assign busy  = ~rst & (((r_state == IDLE) & w_start) | (r_state == ACCESS));
    assign dload = r_dload;

    // A simultaneous read and write request is latched as a write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr    <= 32'h0;
            r_wdata   <= 32'h0;
            r_size    <= SIZE_BYTE;
            r_signed  <= 1'b0;
            r_isWrite <= 1'b0;
        end else if (r_state == IDLE && w_start) begin
            r_addr    <= req_addr;
            r_wdata   <= req_wdata;
            r_size    <= req_size;
            r_signed  <= req_signed;
            r_isWrite <= req_write;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flushed <= 1'b0;
        end else if (r_state != ACCESS) begin
            r_flushed <= 1'b0;
        end else if (flush) begin
            r_flushed <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dload <= 32'h0;
        end else if (r_state == IDLE && w_start && w_misStart) begin
            r_dload <= 32'h0;
        end else if (r_state == ACCESS && mem_ready && !w_squash && !r_isWrite) begin
            r_dload <= w_loadWord;
        end
    end

endmodule

// File: tb/tb_lsu_controller.sv
// Self-checking bench for lsu_controller: scoreboard of expected bus fields and load results.
// Covers the misalignment trap when built with LSU_MISALIGN_TRAP_EN.
module tb_lsu_controller;

    logic        clk;
    logic        rst;
    logic        req_read;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_signed;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] dload;
    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_strb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
`ifdef LSU_MISALIGN_TRAP_EN
    logic        misalign;
`endif

    typedef struct {
        logic        isWrite;
        logic [31:0] memAddr;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic [31:0] dload;
        logic        doneExp;
    } exp_t;

    exp_t        sbQ[$];
    int          testCount;
    int          failCount;
    logic [31:0] lastDload;

    lsu_controller dut (
        .clk        (clk),
        .rst        (rst),
        .req_read   (req_read),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_size   (req_size),
        .req_signed (req_signed),
        .flush      (flush),
        .busy       (busy),
        .done       (done),
        .dload      (dload),
        .mem_ren    (mem_ren),
        .mem_wen    (mem_wen),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_strb   (mem_strb),
`ifdef LSU_MISALIGN_TRAP_EN
        .misalign   (misalign),
`endif
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [3:0] modelStrb(input logic [1:0] size, input logic [1:0] a);
        logic [3:0] s;
        s = 4'h0;
        if (size == 2'd0) s[a] = 1'b1;
        else if (size == 2'd1) s = a[1] ? 4'b1100 : 4'b0011;
        else s = 4'b1111;
        return s;
    endfunction

    function automatic logic [31:0] modelWdata(input logic [1:0] size, input logic [31:0] d);
        if (size == 2'd0) return {24'h0, d[7:0]} * 32'h01010101;
        if (size == 2'd1) return {16'h0, d[15:0]} * 32'h00010001;
        return d;
    endfunction

    function automatic logic [31:0] modelLoad(input logic [31:0] rd, input logic [1:0] a,
                                              input logic [1:0] size, input logic sgn);
        logic [31:0] sh;
        if (size == 2'd0) begin
            sh = rd >> (8 * a);
            return (sgn && sh[7]) ? (sh | 32'hFFFFFF00) : (sh & 32'h000000FF);
        end
        if (size == 2'd1) begin
            sh = rd >> (a[1] ? 16 : 0);
            return (sgn && sh[15]) ? (sh | 32'hFFFF0000) : (sh & 32'h0000FFFF);
        end
        return rd;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [1:0] size, input logic sgn,
                                 input logic [31:0] rdata, input int waits, input int flushAt,
                                 input bit flushIdle, input bit pokeDone);
        exp_t e;
        exp_t head;
        e.isWrite = wr;
        e.memAddr = {addr[31:2], 2'b00};
        e.strb    = wr ? modelStrb(size, addr[1:0]) : 4'h0;
        e.wdata   = wr ? modelWdata(size, wdata) : 32'h0;
        e.doneExp = (flushAt < 0);
        e.dload   = (wr || flushAt >= 0) ? lastDload : modelLoad(rdata, addr[1:0], size, sgn);
        if (!flushIdle) sbQ.push_back(e);

        @(negedge clk);
        req_read = rd; req_write = wr; req_addr = addr; req_wdata = wdata;
        req_size = size; req_signed = sgn; flush = flushIdle;
        #1;
        checkOutput("busyReq", busy, !flushIdle);
        checkOutput("doneReq", done, 1'b0);

        @(negedge clk);
        req_read = 1'b0; req_write = 1'b0; req_addr = 32'hDEADBEEF;
        req_wdata = 32'h0; req_size = 2'd3; req_signed = 1'b0; flush = 1'b0;
        if (flushIdle) begin
            #1;
            checkOutput("idleRen", mem_ren, 1'b0);
            checkOutput("idleBusy", busy, 1'b0);
            return;
        end

        head = sbQ[0];
        for (int w = 0; w <= waits; w++) begin
            mem_ready = (w == waits);
            mem_rdata = (w == waits) ? rdata : 32'h5A5A5A5A;
            flush     = (w == flushAt);
            #1;
            checkOutput("memRen", mem_ren, !head.isWrite);
            checkOutput("memWen", mem_wen, head.isWrite);
            checkOutput("memAddr", mem_addr, head.memAddr);
            checkOutput("memStrb", mem_strb, head.strb);
            checkOutput("memWdata", mem_wdata, head.wdata);
            checkOutput("busyAcc", busy, 1'b1);
            checkOutput("doneAcc", done, 1'b0);
            @(negedge clk);
        end

        mem_ready = 1'b0; flush = 1'b0; mem_rdata = 32'h0;
        if (pokeDone) begin
            req_read = 1'b1; req_addr = 32'h40; req_size = 2'd2;
        end
        #1;
        e = sbQ.pop_front();
        checkOutput("done", done, e.doneExp);
        checkOutput("dload", dload, e.dload);
        checkOutput("busyEnd", busy, (pokeDone && !e.doneExp) ? 1'b1 : 1'b0);
        checkOutput("renEnd", mem_ren, 1'b0);
        lastDload = e.dload;

        @(negedge clk);
        req_read = 1'b0;
        #1;
        checkOutput("doneGone", done, 1'b0);
        checkOutput("renAfter", mem_ren, 1'b0);
    endtask

    initial begin
        testCount = 0; failCount = 0; lastDload = 32'h0;
        rst = 1'b1; req_read = 1'b0; req_write = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        req_size = 2'd0; req_signed = 1'b0; flush = 1'b0; mem_ready = 1'b0; mem_rdata = 32'h0;
        @(negedge clk); @(negedge clk);
        #1;
        checkOutput("rstBusy", busy, 1'b0);
        checkOutput("rstDone", done, 1'b0);
        checkOutput("rstDload", dload, 32'h0);
        checkOutput("rstRen", mem_ren, 1'b0);
        checkOutput("rstWen", mem_wen, 1'b0);
        rst = 1'b0;

        applyStimulus(1, 0, 32'h00001003, 32'h0, 2'd0, 1, 32'h80AABBCC, 0, -1, 0, 0);
        applyStimulus(0, 1, 32'h00002002, 32'h0000BEEF, 2'd1, 0, 32'h0, 3, -1, 0, 0);
        applyStimulus(1, 0, 32'h00000002, 32'h0, 2'd1, 0, 32'h8001FFFF, 0, -1, 0, 0);
        applyStimulus(1, 0, 32'h00000010, 32'h0, 2'd0, 0, 32'h11111111, 2, 0, 0, 0);
        applyStimulus(1, 1, 32'h00000101, 32'h12345678, 2'd0, 0, 32'h0, 1, -1, 0, 0);
        applyStimulus(1, 0, 32'h00000010, 32'h0, 2'd3, 1, 32'hCAFEBABE, 1, -1, 0, 0);
        applyStimulus(1, 0, 32'h00000022, 32'h0, 2'd0, 0, 32'h00F00000, 0, -1, 0, 1);
        applyStimulus(1, 0, 32'h00000030, 32'h0, 2'd1, 1, 32'h12348765, 0, -1, 0, 0);
        applyStimulus(0, 1, 32'h00000044, 32'hA5A5C3C3, 2'd2, 0, 32'h0, 0, -1, 0, 0);
        applyStimulus(1, 0, 32'h00000050, 32'h0, 2'd2, 0, 32'h0, 0, -1, 1, 0);

        // Asynchronous reset in the middle of a read access.
        @(negedge clk);
        req_read = 1'b1; req_addr = 32'h00003000; req_size = 2'd2;
        @(negedge clk);
        req_read = 1'b0;
        #1;
        checkOutput("preRstRen", mem_ren, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("midRstRen", mem_ren, 1'b0);
        checkOutput("midRstAddr", mem_addr, 32'h0);
        checkOutput("midRstBusy", busy, 1'b0);
        checkOutput("midRstDone", done, 1'b0);
        checkOutput("midRstDload", dload, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        lastDload = 32'h0;
        applyStimulus(1, 0, 32'h00000005, 32'h0, 2'd0, 1, 32'h00007F00, 0, -1, 0, 0);

`ifdef LSU_MISALIGN_TRAP_EN
        @(negedge clk);
        req_read = 1'b1; req_addr = 32'h00000006; req_size = 2'd2; req_signed = 1'b0;
        #1;
        checkOutput("misBusy", busy, 1'b1);
        @(negedge clk);
        req_read = 1'b0;
        #1;
        checkOutput("misDone", done, 1'b1);
        checkOutput("misFlag", misalign, 1'b1);
        checkOutput("misRen", mem_ren, 1'b0);
        checkOutput("misDload", dload, 32'h0);
        @(negedge clk);
        #1;
        checkOutput("misDoneGone", done, 1'b0);
        checkOutput("misFlagGone", misalign, 1'b0);
        lastDload = 32'h0;
`else
        applyStimulus(1, 0, 32'h00000006, 32'h0, 2'd2, 0, 32'h11223344, 0, -1, 0, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/lsu_controller.md
LSU_CONTROLLER -- requirements
Module: lsu_controller

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-003 SHALL have port req_read, input, 1 bit: the memory-stage instruction is a load.
REQ-004 SHALL have port req_write, input, 1 bit: the memory-stage instruction is a store.
REQ-005 SHALL have port req_addr, input, 32 bits: byte address (ALU output).
REQ-006 SHALL have port req_wdata, input, 32 bits: store data, right-justified.
REQ-007 SHALL have port req_size, input, 2 bits: 0 byte, 1 halfword, 2 word; 3 is treated as word.
REQ-008 SHALL have port req_signed, input, 1 bit: 1 sign-extends loads, 0 zero-extends.
REQ-009 SHALL have port flush, input, 1 bit: squash the current memory-stage instruction.
REQ-010 SHALL have port busy, output, 1 bit: pipeline stall request.
REQ-011 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-012 SHALL have port dload, output, 32 bits: extended load result, feeding the writeback latch.
REQ-013 SHALL have ports mem_ren (output, 1 bit), mem_wen (output, 1 bit), mem_addr (output, 32 bits), mem_wdata (output, 32 bits), mem_strb (output, 4 bits): data bus request.
REQ-014 SHALL have ports mem_ready (input, 1 bit) and mem_rdata (input, 32 bits): bus completion and read data.

Function
REQ-015 SHALL implement FSM states IDLE, ACCESS and DONE.
REQ-016 IDLE SHALL go to ACCESS when (req_read|req_write) & !flush, latching addr, size, signed, data and direction.
REQ-017 If req_read and req_write are both high, the request SHALL be treated as a write.
REQ-018 ACCESS SHALL hold mem_ren or mem_wen, mem_addr = {addr[31:2],2'b00}, mem_strb and mem_wdata stable until mem_ready.
REQ-019 ACCESS SHALL go to DONE on mem_ready, registering dload for reads; minimum latency is req to done = 2 cycles with mem_ready high in the first ACCESS cycle.
REQ-020 DONE SHALL assert done and busy=0 for exactly one cycle, ignore req_* inputs, and return to IDLE.
REQ-021 busy SHALL be combinational: (IDLE & (req_read|req_write) & !flush) | ACCESS.
REQ-022 Strobes SHALL be: byte 4'b0001<<addr[1:0]; half 4'b0011<<{addr[1],1'b0}; word 4'hF.
REQ-023 Write data SHALL be lane-replicated: byte {4{d[7:0]}}, half {2{d[15:0]}}, word d.
REQ-024 Loads SHALL select the byte lane addr[1:0] or half lane addr[1], then sign- or zero-extend to 32 bits.
REQ-025 flush in ACCESS SHALL NOT drop the bus request; on mem_ready the FSM SHALL go to IDLE with no done pulse and dload unchanged.
REQ-026 flush in IDLE SHALL block the start; flush in DONE SHALL have no effect.
REQ-027 mem_wdata and mem_strb SHALL be 0 whenever mem_wen=0.

Reset
REQ-028 rst SHALL force state IDLE and set busy, done, mem_ren, mem_wen, mem_strb, mem_addr, mem_wdata, dload and misalign to 0, mid-transaction included, without waiting for mem_ready.

Configuration
REQ-029 With LSU_MISALIGN_TRAP_EN defined, the block SHALL have output misalign (1 bit).
REQ-030 With LSU_MISALIGN_TRAP_EN defined, a half access with addr[0]=1 or a word access with addr[1:0]!=0 SHALL skip ACCESS, issue no bus request, and enter DONE with done=1, misalign=1 and dload=0.
REQ-031 Without LSU_MISALIGN_TRAP_EN, the port SHALL be absent, address low bits outside REQ-022/024 SHALL be ignored, and every access SHALL be issued.

Structure
REQ-032 lsu_state_t (IDLE/ACCESS/DONE) and the size constants SIZE_BYTE, SIZE_HALF and SIZE_WORD SHALL live in common_types_pkg.
REQ-033 Load lane select and extension SHALL be a combinational sub-module lsu_load_align (inputs rdata, addr[1:0], size, signed; output word).

Verification
REQ-034 Load byte signed, addr 0x1003, mem_rdata 0x80AABBCC, mem_ready on first ACCESS cycle -> mem_addr 0x1000, dload 0xFFFFFF80, done at cycle 2.
REQ-035 Store half, addr 0x2002, wdata 0x0000BEEF -> mem_strb 4'b1100, mem_wdata 0xBEEFBEEF, mem_wen held through 3 wait cycles, busy=1 throughout.
REQ-036 Load half unsigned, addr 0x0002, rdata 0x8001FFFF -> dload 0x00008001.
REQ-037 Flush raised during ACCESS with mem_ready delayed 2 cycles -> bus held, no done pulse, return to IDLE.
REQ-038 rst asserted during ACCESS -> all outputs 0 asynchronously; the next request starts cleanly.
REQ-039 With LSU_MISALIGN_TRAP_EN defined, word load at 0x0006 -> no mem_ren, misalign=1, done=1 one cycle after req.
